// File: rtl/ysyx_22040931_bpu.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters,
// trained by decode resolution, plus prediction-accuracy counters.
module ysyx_22040931_bpu #(
   parameter int IDX_W = 4,
   parameter int TAG_W = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_valid,
   input  logic [63:0] if_pc,
   output logic        pre_jump,
   output logic [63:0] pre_branch,
   output logic [63:0] if_npc,
   input  logic        upd_valid,
   input  logic [63:0] upd_pc,
   input  logic [1:0]  upd_jumptype,
   input  logic        upd_taken,
   input  logic [63:0] upd_target,
   input  logic        upd_error,
   output logic [31:0] br_total,
   output logic [31:0] br_correct
);

   localparam int N = 1 << IDX_W;

   logic [N-1:0]     vld_q;
   logic [1:0]       ctr_q [N];
   logic [TAG_W-1:0] tag_q [N];
   logic [63:0]      tgt_q [N];
   logic [1:0]       typ_q [N];
   logic [31:0]      total_q;
   logic [31:0]      correct_q;

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;

   assign f_idx = if_pc[IDX_W+1:2];
   assign f_tag = if_pc[2+IDX_W +: TAG_W];
   assign f_hit = if_valid && !reset && vld_q[f_idx]
                  && (tag_q[f_idx] == f_tag);

   always_comb begin
      pre_jump = 1'b0;
      if (f_hit) begin
         unique case (typ_q[f_idx])
            2'b01:        pre_jump = ctr_q[f_idx][1];
            2'b10, 2'b11: pre_jump = 1'b1;
            default:      pre_jump = 1'b0;
         endcase
      end
   end

   assign pre_branch = pre_jump ? tgt_q[f_idx] : 64'd0;
   assign if_npc     = pre_jump ? pre_branch : if_pc + 64'd4;

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic             u_ctl;
   logic [1:0]       u_ctr;
   logic             ctr_we;
   logic             meta_we;
   logic             vld_set;
   logic             vld_clr;
   logic [1:0]       ctr_n;
   logic             unused_pc_bits;

   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[2+IDX_W +: TAG_W];
   assign u_hit = vld_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_ctl = upd_valid && (upd_jumptype != 2'b00);
   assign u_ctr = ctr_q[u_idx];
   assign unused_pc_bits = ^{upd_pc[1:0], upd_pc[63:2+IDX_W+TAG_W]};

   always_comb begin
      ctr_we  = 1'b0;
      meta_we = 1'b0;
      vld_set = 1'b0;
      vld_clr = 1'b0;
      ctr_n   = u_ctr;
      if (upd_valid && !reset) begin
         if (u_hit && upd_jumptype != 2'b00) begin
            ctr_we  = 1'b1;
            meta_we = upd_taken;
            if (upd_jumptype != 2'b01)
               ctr_n = 2'b11;
            else if (upd_taken)
               ctr_n = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
            else
               ctr_n = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
         end else if (!u_hit && upd_jumptype != 2'b00 && upd_taken) begin
            // direct-mapped: the new branch simply evicts whatever was here
            ctr_we  = 1'b1;
            meta_we = 1'b1;
            vld_set = 1'b1;
            ctr_n   = (upd_jumptype == 2'b01) ? 2'b10 : 2'b11;
         end else if (u_hit && upd_jumptype == 2'b00) begin
            vld_clr = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < N; i++) ctr_q[i] <= 2'b00;
      end else begin
         if (vld_set) vld_q[u_idx] <= 1'b1;
         if (vld_clr) vld_q[u_idx] <= 1'b0;
         if (ctr_we)  ctr_q[u_idx] <= ctr_n;
      end
   end

   always_ff @(posedge clock) begin
      if (meta_we) begin
         tag_q[u_idx] <= u_tag;
         tgt_q[u_idx] <= upd_target;
         typ_q[u_idx] <= upd_jumptype;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         total_q   <= 32'd0;
         correct_q <= 32'd0;
      end else if (u_ctl) begin
         total_q <= total_q + 32'd1;
         if (!upd_error) correct_q <= correct_q + 32'd1;
      end
   end

   assign br_total   = total_q;
   assign br_correct = correct_q;

endmodule
